// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg : shared opcode nibbles, fetch state encoding and datapath widths.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_HALT   = 4'hF;
  localparam logic [3:0] OP_JZ_REG = 4'h6;
  localparam logic [3:0] OP_JZ_IMM = 4'h7;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

  function automatic logic is_halt(input logic [3:0] op_nibble);
    return op_nibble == OP_HALT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if : req/ack instruction memory bus (master = fetch unit).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface instr_fetch_unit_if #(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
);

  logic               req;
  logic [PC_W-1:0]    addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

`default_nettype wire

// File: rtl/pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg : program counter, LoadPC beats IncPC, SelPC picks immediate/register.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_reg #(
  parameter int              PC_W     = cpu_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_pc,
  input  logic            inc_pc,
  input  logic            sel_pc,
  input  logic [7:0]      imm,
  input  logic [PC_W-1:0] reg_target,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_pc) begin
      pc_d = sel_pc ? PC_W'(imm) : reg_target;
    end else if (inc_pc) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit : owns PC/IR, fetches over req/ack, stalls the controller.
// Optional watchdog enabled by FETCH_TIMEOUT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_fetch_unit #(
  parameter int              PC_W        = cpu_pkg::PC_W,
  parameter int              INSTR_W     = cpu_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              TIMEOUT_CYC = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      LoadIR,
  input  logic                      IncPC,
  input  logic                      SelPC,
  input  logic                      LoadPC,
  input  logic [PC_W-1:0]           RegTarget,
  instr_fetch_unit_if.master        imem,
  output logic [7:0]                Opcode,
  output logic [7:0]                Immediate,
  output logic                      ir_valid,
  output logic                      fetch_busy,
  output logic                      halted,
  output logic                      overrun,
  output logic                      fetch_err
);

  import cpu_pkg::*;

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic               ir_valid_q, ir_valid_d;
  logic               halted_q, halted_d;
  logic               overrun_q, overrun_d;
  logic               err_q, err_d;
  logic [PC_W-1:0]    pc;
  logic               timeout;

  // Jump-by-immediate reads the IR as registered, never the word arriving now.
  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .load_pc    (LoadPC),
    .inc_pc     (IncPC),
    .sel_pc     (SelPC),
    .imm        (ir_q[7:0]),
    .reg_target (RegTarget),
    .pc         (pc)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (!imem.ack) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = (cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYC);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    addr_d     = addr_q;
    ir_valid_d = ir_valid_q;
    halted_d   = halted_q;
    overrun_d  = overrun_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (LoadIR) begin
          if (halted_q) begin
            overrun_d = 1'b1;
          end else begin
            addr_d     = pc;
            ir_valid_d = 1'b0;
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        if (LoadIR) begin
          overrun_d = 1'b1;
        end
        // A same-cycle ack wins over the watchdog.
        if (imem.ack) begin
          ir_d       = imem.rdata;
          ir_valid_d = 1'b1;
          halted_d   = halted_q | is_halt(imem.rdata[15:12]);
          state_d    = IDLE;
        end else if (timeout) begin
          ir_d       = '0;
          ir_valid_d = 1'b1;
          err_d      = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      ir_q       <= '0;
      addr_q     <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      overrun_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      addr_q     <= addr_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
      overrun_q  <= overrun_d;
      err_q      <= err_d;
    end
  end

  assign imem.req   = (state_q == WAIT);
  assign imem.addr  = addr_q;
  assign fetch_busy = (state_q == WAIT);
  assign Opcode     = ir_q[15:8];
  assign Immediate  = ir_q[7:0];
  assign ir_valid   = ir_valid_q;
  assign halted     = halted_q;
  assign overrun    = overrun_q;
  assign fetch_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit : directed scenarios plus random traffic vs a spec model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch_unit;

  import cpu_pkg::*;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        LoadIR = 1'b0, IncPC = 1'b0, SelPC = 1'b0, LoadPC = 1'b0;
  logic [7:0]  RegTarget = 8'h00;
  logic [7:0]  Opcode, Immediate;
  logic        ir_valid, fetch_busy, halted, overrun, fetch_err;

  int n_checks = 0;
  int n_pass   = 0;

  instr_fetch_unit_if #(.PC_W(8), .INSTR_W(16)) imem ();

  instr_fetch_unit #(
    .PC_W        (8),
    .INSTR_W     (16),
    .RESET_PC    (8'h00),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .LoadIR     (LoadIR),
    .IncPC      (IncPC),
    .SelPC      (SelPC),
    .LoadPC     (LoadPC),
    .RegTarget  (RegTarget),
    .imem       (imem),
    .Opcode     (Opcode),
    .Immediate  (Immediate),
    .ir_valid   (ir_valid),
    .fetch_busy (fetch_busy),
    .halted     (halted),
    .overrun    (overrun),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  // Reference model state: what the fetch unit should hold after each edge.
  int          m_pc;
  logic [15:0] m_ir;
  logic [7:0]  m_addr;
  bit          m_valid, m_halted, m_overrun, m_pending, m_err;
  int          m_waited;

  task automatic model_reset();
    m_pc = 0; m_ir = 16'h0000; m_addr = 8'h00; m_valid = 0; m_halted = 0;
    m_overrun = 0; m_pending = 0; m_err = 0; m_waited = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0; LoadIR = 0; IncPC = 0; SelPC = 0; LoadPC = 0; RegTarget = 8'h00;
    imem.ack = 1'b0; imem.rdata = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
  endtask

  // Drive one cycle of inputs, advance the model by the spec rules, then clock.
  task automatic step(input bit lir, input bit inc, input bit sel, input bit lpc,
                      input logic [7:0] tgt, input bit ack, input logic [15:0] rd);
    int next_pc;
    LoadIR = lir; IncPC = inc; SelPC = sel; LoadPC = lpc; RegTarget = tgt;
    imem.ack = ack; imem.rdata = rd;
    if (lpc)      next_pc = sel ? int'(m_ir[7:0]) : int'(tgt);
    else if (inc) next_pc = (m_pc + 1) % 256;
    else          next_pc = m_pc;
    if (!m_pending) begin
      if (lir) begin
        if (m_halted) m_overrun = 1;
        else begin
          m_pending = 1; m_addr = 8'(m_pc); m_valid = 0; m_waited = 0;
        end
      end
    end else begin
      if (lir) m_overrun = 1;
      if (ack) begin
        m_ir = rd; m_valid = 1; m_pending = 0;
        if (rd[15:12] == OP_HALT) m_halted = 1;
      end
`ifdef FETCH_TIMEOUT_EN
      else begin
        m_waited++;
        if (m_waited == TIMEOUT) begin
          m_ir = 16'h0000; m_valid = 1; m_pending = 0; m_err = 1;
        end
      end
`endif
    end
    m_pc = next_pc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00, 0, 16'h0000);
  endtask

  task automatic test_reset();
    logic [29:0] obs;
    do_reset();
    obs = {imem.req, imem.addr, Opcode, Immediate, ir_valid, fetch_busy, halted, overrun, fetch_err};
    n_checks++;
    if (obs !== 30'h0) $display("FAIL reset_outputs: got %h want 0", obs);
    else n_pass++;
  endtask

  task automatic test_basic_fetch();
    int busy_cycles = 0;
    step(1, 0, 0, 0, 8'h00, 0, 16'h0000);
    n_checks++;
    if (imem.req !== 1'b1 || imem.addr !== 8'h00)
      $display("FAIL fetch_issue: got req=%b addr=%h want req=1 addr=00", imem.req, imem.addr);
    else n_pass++;
    if (fetch_busy) busy_cycles++;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 8'h00, 0, 16'h0000);
      if (fetch_busy) busy_cycles++;
    end
    step(0, 0, 0, 0, 8'h00, 1, 16'h4103);
    if (fetch_busy) busy_cycles++;
    n_checks++;
    if (busy_cycles !== 4) $display("FAIL busy_length: got %0d want 4", busy_cycles);
    else n_pass++;
    n_checks++;
    if (Opcode !== 8'h41 || Immediate !== 8'h03 || ir_valid !== 1'b1 || imem.req !== 1'b0)
      $display("FAIL fetch_data: got op=%h imm=%h v=%b req=%b want 41 03 1 0",
               Opcode, Immediate, ir_valid, imem.req);
    else n_pass++;
    step(0, 1, 0, 0, 8'h00, 0, 16'h0000);
    step(1, 0, 0, 0, 8'h00, 0, 16'h0000);
    n_checks++;
    if (imem.addr !== 8'h01) $display("FAIL incpc_addr: got %h want 01", imem.addr);
    else n_pass++;
    step(0, 0, 0, 0, 8'h00, 1, 16'h7020);
  endtask

  task automatic test_jump_priority();
    step(0, 1, 1, 1, 8'h99, 0, 16'h0000);
    step(1, 0, 0, 0, 8'h00, 0, 16'h0000);
    n_checks++;
    if (imem.addr !== 8'h20) $display("FAIL loadpc_priority: got %h want 20", imem.addr);
    else n_pass++;
    // Jump-by-immediate in the ack cycle must use the old IR (0x20), not 0x3377.
    step(0, 0, 1, 1, 8'h00, 1, 16'h3377);
    step(1, 0, 0, 0, 8'h00, 0, 16'h0000);
    n_checks++;
    if (imem.addr !== 8'h20) $display("FAIL sel_uses_old_ir: got %h want 20", imem.addr);
    else n_pass++;
    step(0, 0, 0, 0, 8'h00, 1, 16'h0000);
  endtask

  task automatic test_wrap();
    step(0, 0, 0, 1, 8'hFF, 0, 16'h0000);
    step(0, 1, 0, 0, 8'h00, 0, 16'h0000);
    step(1, 0, 0, 0, 8'h00, 0, 16'h0000);
    n_checks++;
    if (imem.addr !== 8'h00) $display("FAIL pc_wrap: got %h want 00", imem.addr);
    else n_pass++;
    step(0, 0, 0, 0, 8'h00, 1, 16'h0000);
    step(0, 0, 0, 1, 8'h5A, 0, 16'h0000);
    step(1, 0, 0, 0, 8'h00, 0, 16'h0000);
    n_checks++;
    if (imem.addr !== 8'h5A) $display("FAIL regtarget: got %h want 5a", imem.addr);
    else n_pass++;
    step(0, 0, 0, 0, 8'h00, 1, 16'h0000);
  endtask

  task automatic test_overrun();
    do_reset();
    step(1, 0, 0, 0, 8'h00, 0, 16'h0000);
    step(1, 1, 0, 0, 8'h00, 0, 16'h0000);
    n_checks++;
    if (overrun !== 1'b1 || imem.req !== 1'b1 || imem.addr !== 8'h00)
      $display("FAIL overrun_wait: got ov=%b req=%b addr=%h want 1 1 00", overrun, imem.req, imem.addr);
    else n_pass++;
    step(0, 0, 0, 0, 8'h00, 1, 16'h1111);
    idle(1);
    n_checks++;
    if (imem.req !== 1'b0 || Opcode !== 8'h11) $display("FAIL single_request: got req=%b op=%h want 0 11", imem.req, Opcode);
    else n_pass++;
    step(0, 0, 0, 0, 8'h00, 1, 16'h5555);
    n_checks++;
    if (Opcode !== 8'h11) $display("FAIL ack_idle_ignored: got %h want 11", Opcode);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    step(1, 0, 0, 0, 8'h00, 0, 16'h0000);
    idle(1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
    n_checks++;
    if (imem.req !== 1'b0) $display("FAIL reset_drops_req: got %b want 0", imem.req);
    else n_pass++;
    step(0, 0, 0, 0, 8'h00, 1, 16'h1234);
    n_checks++;
    if (Opcode !== 8'h00 || ir_valid !== 1'b0) $display("FAIL late_ack: got op=%h v=%b want 00 0", Opcode, ir_valid);
    else n_pass++;
  endtask

  task automatic test_halt();
    do_reset();
    step(1, 0, 0, 0, 8'h00, 0, 16'h0000);
    step(0, 0, 0, 0, 8'h00, 1, 16'hF000);
    n_checks++;
    if (halted !== 1'b1 || Opcode !== 8'hF0) $display("FAIL halt_set: got h=%b op=%h want 1 f0", halted, Opcode);
    else n_pass++;
    step(1, 0, 0, 0, 8'h00, 0, 16'h0000);
    n_checks++;
    if (imem.req !== 1'b0 || fetch_busy !== 1'b0 || overrun !== 1'b1)
      $display("FAIL halt_blocks: got req=%b busy=%b ov=%b want 0 0 1", imem.req, fetch_busy, overrun);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int busy_cycles = 0;
    do_reset();
    step(1, 0, 0, 0, 8'h00, 0, 16'h0000);
    for (int i = 0; i < 40 && fetch_busy; i++) begin
      busy_cycles++;
      step(0, 0, 0, 0, 8'h00, 0, 16'h0000);
    end
`ifdef FETCH_TIMEOUT_EN
    n_checks++;
    if (busy_cycles !== TIMEOUT || fetch_err !== 1'b1 || Opcode !== 8'h00 || ir_valid !== 1'b1)
      $display("FAIL timeout: got cyc=%0d err=%b op=%h v=%b want %0d 1 00 1",
               busy_cycles, fetch_err, Opcode, ir_valid, TIMEOUT);
    else n_pass++;
    do_reset();
    step(1, 0, 0, 0, 8'h00, 0, 16'h0000);
    idle(TIMEOUT - 1);
    step(0, 0, 0, 0, 8'h00, 1, 16'h2233);
    n_checks++;
    if (fetch_err !== 1'b0 || Opcode !== 8'h22 || fetch_busy !== 1'b0)
      $display("FAIL ack_beats_timeout: got err=%b op=%h busy=%b want 0 22 0", fetch_err, Opcode, fetch_busy);
    else n_pass++;
`else
    n_checks++;
    if (busy_cycles !== 40 || fetch_err !== 1'b0)
      $display("FAIL wait_forever: got cyc=%0d err=%b want 40 0", busy_cycles, fetch_err);
    else n_pass++;
    step(0, 0, 0, 0, 8'h00, 1, 16'h2233);
`endif
  endtask

  task automatic test_random();
    logic [29:0] obs, exp;
    logic [15:0] rd;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rd = 16'($urandom);
      if (rd[15:12] == OP_HALT) rd[15:12] = OP_NOP;
      step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, 1'($urandom),
           $urandom_range(0, 5) == 0, 8'($urandom), 1'($urandom), rd);
      obs = {imem.req, imem.addr, Opcode, Immediate, ir_valid, fetch_busy, halted, overrun, fetch_err};
      exp = {m_pending, m_addr, m_ir[15:8], m_ir[7:0], m_valid, m_pending, m_halted, m_overrun, m_err};
      n_checks++;
      if (obs !== exp) $display("FAIL random_cycle_%0d: got %h want %h", i, obs, exp);
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    imem.ack = 1'b0;
    imem.rdata = 16'h0000;
    test_reset();
    test_basic_fetch();
    test_jump_priority();
    test_wrap();
    test_overrun();
    test_reset_mid_fetch();
    test_halt();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
